// File: rtl/jtag_shift_pkg.sv
// Shared types and constants for the JTAG shift engine.
// Holds the FSM state encoding, the command length width and default sizes.
package jtag_shift_pkg;

    localparam int LEN_W            = 6;
    localparam int DEF_MAX_BITS     = 32;
    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_TRST_CYCLES  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_RSP,
        ST_TRST
    } state_e;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK phase timer: counts CLK_DIV io_clk cycles per TCK half-period.
// Ports: clk_i, reset_i (sync, active-high), start_i (clear on command
// accept), busy_i (a TCK phase is running), phase_end_o (last cycle of phase).
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic busy_i,
    output logic phase_end_o
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_end_o = busy_i && !start_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (start_i || !busy_i || phase_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master: shifts TMS/TDI vectors out on a generated TCK, captures TDO.
// Ports: io_clk, io_reset (sync, active-high); cmd_* valid/ready command in;
// rsp_* valid/ready captured-TDO response; io_jtag_tck/tms/tdi out, tdo in.
// Define JTAG_SHIFT_ENGINE_TRST_EN to add cmd_trst and io_jtag_trstn.
module jtag_shift_engine
    import jtag_shift_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int MAX_BITS    = DEF_MAX_BITS,
    parameter int TRST_CYCLES = DEF_TRST_CYCLES
) (
    input  logic                io_clk,
    input  logic                io_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_tms,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                io_jtag_tck,
    output logic                io_jtag_tms,
    output logic                io_jtag_tdi,
    input  logic                io_jtag_tdo
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
    ,
    input  logic                cmd_trst,
    output logic                io_jtag_trstn
`endif
);

    localparam int IW = $clog2(MAX_BITS) + 1;

    state_e state_q;
    state_e state_d;

    logic [IW-1:0]       len_q, len_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [MAX_BITS-1:0] tms_sh_q, tms_sh_d;
    logic [MAX_BITS-1:0] tdi_sh_q, tdi_sh_d;
    logic [MAX_BITS-1:0] mask_q, mask_d;
    logic [MAX_BITS-1:0] tdo_q, tdo_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;

`ifdef JTAG_SHIFT_ENGINE_TRST_EN
    localparam int TW = $clog2(TRST_CYCLES) + 1;
    localparam logic [TW-1:0] TRST_LAST = TW'(TRST_CYCLES - 1);
    logic [TW-1:0] trst_cnt_q, trst_cnt_d;
    logic          trstn_q, trstn_d;
    logic          trst_done;
    assign trst_done     = (trst_cnt_q == TRST_LAST);
    assign io_jtag_trstn = trstn_q;
`endif

    logic             accept;
    logic             phase_end;
    logic             is_last;
    logic [LEN_W-1:0] len_clamp;

    assign accept    = (state_q == ST_IDLE) && cmd_valid;
    assign is_last   = (idx_q == len_q - 1'b1);
    assign len_clamp = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS)
                                                    : cmd_len;

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk_i      (io_clk),
        .reset_i    (io_reset),
        .start_i    (accept),
        .busy_i     ((state_q == ST_LOW) || (state_q == ST_HIGH)),
        .phase_end_o(phase_end)
    );

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RSP);
    assign rsp_tdo     = tdo_q;
    assign io_jtag_tck = tck_q;
    assign io_jtag_tms = tms_q;
    assign io_jtag_tdi = tdi_q;

    always_ff @(posedge io_clk) begin
        if (io_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
                    if (cmd_trst) begin
                        state_d = ST_TRST;
                    end else
`endif
                    if (len_clamp == '0) begin
                        state_d = ST_RSP;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (phase_end) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_end) state_d = is_last ? ST_RSP : ST_LOW;
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
            ST_TRST: begin
                if (trst_done) state_d = ST_RSP;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d    = len_q;
        idx_d    = idx_q;
        tms_sh_d = tms_sh_q;
        tdi_sh_d = tdi_sh_q;
        mask_d   = mask_q;
        tdo_d    = tdo_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
        trst_cnt_d = trst_cnt_q;
        trstn_d    = trstn_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d    = IW'(len_clamp);
                    idx_d    = '0;
                    tms_sh_d = cmd_tms;
                    tdi_sh_d = cmd_tdi;
                    mask_d   = MAX_BITS'(1);
                    tdo_d    = '0;
                    tck_d    = 1'b0;
                    if (len_clamp != '0) begin
                        tms_d = cmd_tms[0];
                        tdi_d = cmd_tdi[0];
                    end
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
                    if (cmd_trst) begin
                        tms_d      = 1'b1;
                        trstn_d    = 1'b0;
                        trst_cnt_d = '0;
                    end
`endif
                end
            end
            ST_LOW: begin
                // TDO is sampled on the same io_clk edge that raises TCK.
                if (phase_end) begin
                    tck_d = 1'b1;
                    tdo_d = tdo_q | (mask_q & {MAX_BITS{io_jtag_tdo}});
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    tck_d = 1'b0;
                    if (!is_last) begin
                        idx_d    = idx_q + 1'b1;
                        mask_d   = mask_q << 1;
                        tms_sh_d = tms_sh_q >> 1;
                        tdi_sh_d = tdi_sh_q >> 1;
                        tms_d    = tms_sh_q[1];
                        tdi_d    = tdi_sh_q[1];
                    end
                end
            end
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
            ST_TRST: begin
                trst_cnt_d = trst_cnt_q + 1'b1;
                if (trst_done) trstn_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge io_clk) begin
        if (io_reset) begin
            len_q    <= '0;
            idx_q    <= '0;
            tms_sh_q <= '0;
            tdi_sh_q <= '0;
            mask_q   <= '0;
            tdo_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
            trst_cnt_q <= '0;
            trstn_q    <= 1'b1;
`endif
        end else begin
            len_q    <= len_d;
            idx_q    <= idx_d;
            tms_sh_q <= tms_sh_d;
            tdi_sh_q <= tdi_sh_d;
            mask_q   <= mask_d;
            tdo_q    <= tdo_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
            trst_cnt_q <= trst_cnt_d;
            trstn_q    <= trstn_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed bench for jtag_shift_engine with a small Shift-DR target model.
// Define JTAG_SHIFT_ENGINE_TRST_EN to also exercise the TRST command.
module tb_jtag_shift_engine;

    localparam int CLK_DIV  = 4;
    localparam int MAX_BITS = 32;

    logic        io_clk    = 1'b0;
    logic        io_reset  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_len   = '0;
    logic [31:0] cmd_tms   = '0;
    logic [31:0] cmd_tdi   = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_tdo;
    logic        io_jtag_tck;
    logic        io_jtag_tms;
    logic        io_jtag_tdi;
    logic        io_jtag_tdo;
    logic        cmd_trst  = 1'b0;
    logic        io_jtag_trstn;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_shift_engine #(
        .CLK_DIV (CLK_DIV),
        .MAX_BITS(MAX_BITS)
    ) dut (
        .io_clk     (io_clk),
        .io_reset   (io_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_tms    (cmd_tms),
        .cmd_tdi    (cmd_tdi),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tdo    (rsp_tdo),
        .io_jtag_tck(io_jtag_tck),
        .io_jtag_tms(io_jtag_tms),
        .io_jtag_tdi(io_jtag_tdi),
        .io_jtag_tdo(io_jtag_tdo)
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
        ,
        .cmd_trst     (cmd_trst),
        .io_jtag_trstn(io_jtag_trstn)
`endif
    );

`ifndef JTAG_SHIFT_ENGINE_TRST_EN
    assign io_jtag_trstn = 1'b1;
`endif

    always #5 io_clk = ~io_clk;

    // Target model: captures TDI on TCK rise, advances TDO on TCK fall.
    // Edges are seen one io_clk after the DUT makes them.
    logic        ld       = 1'b0;
    logic [31:0] ld_val   = '0;
    logic [31:0] dr       = '0;
    logic [31:0] cap      = '0;
    logic        tck_prev = 1'b0;
    int          rises    = 0;
    time         rise_t [64];
    logic        rise_tms [64];

    assign io_jtag_tdo = dr[0];

    always @(posedge io_clk) begin
        if (ld) begin
            dr    <= ld_val;
            cap   <= '0;
            rises <= 0;
        end else begin
            if (!tck_prev && io_jtag_tck) begin
                cap <= {io_jtag_tdi, cap[31:1]};
                if (rises < 64) begin
                    rise_t[rises]   <= $time;
                    rise_tms[rises] <= io_jtag_tms;
                end
                rises <= rises + 1;
            end
            if (tck_prev && !io_jtag_tck) begin
                dr <= {1'b0, dr[31:1]};
            end
        end
        tck_prev <= io_jtag_tck;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_model(input logic [31:0] v);
        @(negedge io_clk);
        ld_val = v;
        ld     = 1'b1;
        @(negedge io_clk);
        ld     = 1'b0;
    endtask

    // lat = cycles from the accept edge until rsp_valid is seen.
    task automatic run_cmd(input logic [5:0] len, input logic [31:0] tms,
                           input logic [31:0] tdi, input int budget,
                           output int lat);
        @(negedge io_clk);
        cmd_len   = len;
        cmd_tms   = tms;
        cmd_tdi   = tdi;
        cmd_valid = 1'b1;
        chk("acc_ready", cmd_ready, 1);
        @(negedge io_clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < budget) begin
            @(negedge io_clk);
            lat++;
        end
    endtask

    task automatic finish_rsp;
        @(negedge io_clk);
        rsp_ready = 1'b1;
        @(negedge io_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_rvalid"}, rsp_valid, 0);
        chk({tag, "_tck"}, io_jtag_tck, 0);
        chk({tag, "_tms"}, io_jtag_tms, 1);
        chk({tag, "_tdi"}, io_jtag_tdi, 0);
        chk({tag, "_tdo"}, rsp_tdo, 0);
    endtask

    initial begin
        int  lat;
        int  r0;
        int  low;
        logic seen;

        // Reset state and quiet idle.
        repeat (3) @(negedge io_clk);
        chk_reset_vals("rst");
        chk("rst_trstn", io_jtag_trstn, 1);
        io_reset = 1'b0;
        load_model(32'h0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge io_clk);
            if (io_jtag_tck) seen = 1'b1;
        end
        chk("idle_tck_high", seen, 0);
        chk("idle_rises", rises, 0);

        // len=5, all TMS ones; upper target bits must not leak.
        load_model(32'hFFFF_FFF5);
        run_cmd(6'd5, 32'h1F, 32'h0, 200, lat);
        chk("l5_lat", lat, 41);
        chk("l5_tdo", rsp_tdo, 32'h15);
        chk("l5_rises", rises, 5);
        for (int i = 1; i < 5; i++)
            chk("l5_period", rise_t[i] - rise_t[i-1], 2 * CLK_DIV * 10);
        for (int i = 0; i < 5; i++)
            chk("l5_tms", rise_tms[i], 1);
        finish_rsp();

        // Full 32-bit IDCODE scan, then hold the response.
        load_model(32'h1000_1FFF);
        run_cmd(6'd32, 32'h8000_0000, 32'hDEAD_BEEF, 400, lat);
        chk("id_lat", lat, 257);
        chk("id_tdo", rsp_tdo, 32'h1000_1FFF);
        chk("id_cap", cap, 32'hDEAD_BEEF);
        chk("id_rises", rises, 32);
        chk("id_last_tms", rise_tms[31], 1);
        chk("id_first_tms", rise_tms[0], 0);
        repeat (20) begin
            @(negedge io_clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_tdo", rsp_tdo, 32'h1000_1FFF);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_tck", io_jtag_tck, 0);
        end
        @(negedge io_clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 6'd0;
        @(negedge io_clk);
        rsp_ready = 1'b0;
        chk("bp_idle_ready", cmd_ready, 1);
        chk("bp_idle_valid", rsp_valid, 0);
        @(negedge io_clk);
        cmd_valid = 1'b0;
        chk("bp_acc2", cmd_ready, 0);
        chk("bp_rsp2", rsp_valid, 1);
        chk("bp_tdo2", rsp_tdo, 0);
        finish_rsp();

        // Reset in HIGH of bit 3 of a len=8 command.
        load_model(32'h0);
        @(negedge io_clk);
        cmd_len   = 6'd8;
        cmd_tms   = 32'h0;
        cmd_tdi   = 32'hFF;
        cmd_valid = 1'b1;
        @(negedge io_clk);
        cmd_valid = 1'b0;
        repeat (29) @(negedge io_clk);
        chk("mr_tck_high", io_jtag_tck, 1);
        chk("mr_rises", rises, 4);
        io_reset = 1'b1;
        @(negedge io_clk);
        io_reset = 1'b0;
        chk_reset_vals("mr");
        r0 = rises;
        seen = 1'b0;
        repeat (50) begin
            @(negedge io_clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", seen, 0);
        chk("mr_no_edge", rises, r0);
        load_model(32'h5);
        run_cmd(6'd3, 32'h0, 32'h3, 200, lat);
        chk("mr_lat", lat, 25);
        chk("mr_tdo", rsp_tdo, 32'h5);
        chk("mr_cap", cap[31:29], 3'b011);
        chk("mr_rises2", rises, 3);
        finish_rsp();

        // Zero-length command.
        load_model(32'hFFFF_FFFF);
        run_cmd(6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, lat);
        chk("z_lat", lat, 1);
        chk("z_tdo", rsp_tdo, 0);
        chk("z_rises", rises, 0);
        finish_rsp();

        // Over-length request clamps to 32 bits.
        load_model(32'hA5A5_A5A5);
        run_cmd(6'd40, 32'h0, 32'h1234_5678, 400, lat);
        chk("cl_lat", lat, 257);
        chk("cl_tdo", rsp_tdo, 32'hA5A5_A5A5);
        chk("cl_rises", rises, 32);
        chk("cl_cap", cap, 32'h1234_5678);
        finish_rsp();

`ifdef JTAG_SHIFT_ENGINE_TRST_EN
        load_model(32'hFFFF_FFFF);
        @(negedge io_clk);
        cmd_len   = 6'd8;
        cmd_valid = 1'b1;
        cmd_trst  = 1'b1;
        @(negedge io_clk);
        cmd_valid = 1'b0;
        cmd_trst  = 1'b0;
        lat = 1;
        low = 0;
        while (!rsp_valid && lat < 100) begin
            if (!io_jtag_trstn) low++;
            @(negedge io_clk);
            lat++;
        end
        chk("trst_low", low, 16);
        chk("trst_lat", lat, 17);
        chk("trst_tdo", rsp_tdo, 0);
        chk("trst_rises", rises, 0);
        chk("trst_end", io_jtag_trstn, 1);
        finish_rsp();
`else
        low = 0;
        chk("trstn_idle", io_jtag_trstn, 1);
`endif

        chk("end_ready", cmd_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
